// File: rtl/sumador_serial_acc.sv
// Digit-serial add/subtract unit with a running accumulator.
// It accepts one operation through a valid/ready handshake, produces DIGIT result bits per clock, and returns the result through a valid/ready handshake.
module sumador_serial_acc #(
    parameter int WIDTH = 5,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("sumador_serial_acc: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]       op_a, op_b, res, acc;
    logic [WIDTH-1:0]       op_a_in, op_b_in;
    logic                   cy;
    logic [CNT_W-1:0]       cnt;
    logic [1:0]             mode_r;
    logic                   sign_a, sign_b;
    logic                   accept, release_out, last_digit;
    logic [DIGIT:0]         dsum;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;

    function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                                 input logic [DIGIT-1:0] y,
                                                 input logic             c);
        return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, c};
    endfunction

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign accept      = in_valid && (state == IDLE);
    assign release_out = out_ready && (state == DONE);
    assign last_digit  = (state == RUN) && (cnt == LAST);

    // The new digit enters from the MSB side, so after N digits the LSB digit is at the bottom.
    assign dsum     = digit_add(op_a[DIGIT-1:0], op_b[DIGIT-1:0], cy);
    assign res_cat  = {dsum[DIGIT-1:0], res};
    assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

    always_comb begin
        op_a_in = a;
        op_b_in = '0;
        case (mode)
            2'b00:   op_b_in = b;
            2'b01:   op_b_in = ~b;
            2'b10: begin
                op_a_in = acc;
                op_b_in = a;
            end
            default: op_b_in = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand shift registers. Stale contents are harmless because the result is taken only after N shifts.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a   <= op_a_in;
            op_b   <= op_b_in;
            cy     <= (mode == 2'b01);
            mode_r <= mode;
            sign_a <= op_a_in[WIDTH-1];
            sign_b <= op_b_in[WIDTH-1];
        end else if (state == RUN) begin
            op_a <= op_a >> DIGIT;
            op_b <= op_b >> DIGIT;
            cy   <= dsum[DIGIT];
            res  <= res_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            acc      <= '0;
        end else begin
            if (accept) begin
                cnt <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + CNT_W'(1);
            end

            // Visible results update only as out_valid rises.
            if (last_digit) begin
                if (mode_r == 2'b11) begin
                    sum      <= '0;
                    carry    <= 1'b0;
                    overflow <= 1'b0;
                end else begin
                    sum      <= res_next;
                    carry    <= dsum[DIGIT];
                    overflow <= (sign_a == sign_b) && (res_next[WIDTH-1] != sign_a);
                end
            end

            if (release_out) begin
                case (mode_r)
                    2'b10:   acc <= sum;
                    2'b11:   acc <= '0;
                    default: acc <= acc;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sumador_serial_acc.sv
// Directed bench for sumador_serial_acc.
// Covers a bit-serial instance (DIGIT=1) and a single-cycle instance (DIGIT=5).
module tb_sumador_serial_acc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0, out_ready = 1'b1;
    logic [4:0] a = '0, b = '0;
    logic [1:0] mode = '0;
    logic       in_ready, out_valid, carry, overflow, busy;
    logic [4:0] sum;

    logic       in_valid5 = 1'b0, out_ready5 = 1'b1;
    logic [4:0] a5 = '0, b5 = '0;
    logic [1:0] mode5 = '0;
    logic       in_ready5, out_valid5, carry5, overflow5, busy5;
    logic [4:0] sum5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sumador_serial_acc #(.WIDTH(5), .DIGIT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .overflow(overflow), .busy(busy)
    );

    sumador_serial_acc #(.WIDTH(5), .DIGIT(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
        .a(a5), .b(b5), .mode(mode5), .out_valid(out_valid5), .out_ready(out_ready5),
        .sum(sum5), .carry(carry5), .overflow(overflow5), .busy(busy5)
    );

    typedef struct {
        logic [1:0] mode;
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] sum;
        logic       carry;
        logic       ov;
        logic [4:0] acc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issues one operation on the serial instance and counts cycles until out_valid.
    task automatic run_op(input logic [1:0] m, input logic [4:0] va, input logic [4:0] vb,
                          output int lat);
        @(negedge clk);
        check("in_ready before accept", {31'd0, in_ready}, 32'd1);
        mode = m; a = va; b = vb; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op5(input logic [1:0] m, input logic [4:0] va, input logic [4:0] vb,
                           output int lat);
        @(negedge clk);
        mode5 = m; a5 = va; b5 = vb; in_valid5 = 1'b1;
        @(posedge clk);
        #1 in_valid5 = 1'b0;
        lat = 0;
        while (!out_valid5 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;

        vecs[0]  = '{2'b00, 5'd13, 5'd9,  5'd22, 1'b0, 1'b1, 5'd0};
        vecs[1]  = '{2'b00, 5'd31, 5'd1,  5'd0,  1'b1, 1'b0, 5'd0};
        vecs[2]  = '{2'b00, 5'd15, 5'd1,  5'd16, 1'b0, 1'b1, 5'd0};
        vecs[3]  = '{2'b01, 5'd9,  5'd13, 5'd28, 1'b0, 1'b0, 5'd0};
        vecs[4]  = '{2'b01, 5'd13, 5'd9,  5'd4,  1'b1, 1'b0, 5'd0};
        vecs[5]  = '{2'b11, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 5'd0};
        vecs[6]  = '{2'b10, 5'd7,  5'd0,  5'd7,  1'b0, 1'b0, 5'd7};
        vecs[7]  = '{2'b10, 5'd7,  5'd0,  5'd14, 1'b0, 1'b0, 5'd14};
        vecs[8]  = '{2'b10, 5'd7,  5'd0,  5'd21, 1'b0, 1'b1, 5'd21};
        vecs[9]  = '{2'b10, 5'd15, 5'd0,  5'd4,  1'b1, 1'b0, 5'd4};
        vecs[10] = '{2'b11, 5'd9,  5'd3,  5'd0,  1'b0, 1'b0, 5'd0};
        vecs[11] = '{2'b10, 5'd6,  5'd0,  5'd6,  1'b0, 1'b0, 5'd6};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst sum", {27'd0, sum}, 32'd0);
        check("rst carry", {31'd0, carry}, 32'd0);
        check("rst overflow", {31'd0, overflow}, 32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst acc", {27'd0, dut.acc}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst in_ready", {31'd0, in_ready}, 32'd1);

        // Table of operations on the serial instance
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].mode, vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d latency", i), lat, 32'd5);
            check($sformatf("vec%0d sum", i), {27'd0, sum}, {27'd0, vecs[i].sum});
            check($sformatf("vec%0d carry", i), {31'd0, carry}, {31'd0, vecs[i].carry});
            check($sformatf("vec%0d overflow", i), {31'd0, overflow}, {31'd0, vecs[i].ov});
            check($sformatf("vec%0d in_ready in DONE", i), {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid after hs", i), {31'd0, out_valid}, 32'd0);
            check($sformatf("vec%0d acc", i), {27'd0, dut.acc}, {27'd0, vecs[i].acc});
            check($sformatf("vec%0d sum held idle", i), {27'd0, sum}, {27'd0, vecs[i].sum});
        end

        // Backpressure: hold the result while in_valid pulses are presented
        out_ready = 1'b0;
        run_op(2'b00, 5'd13, 5'd9, lat);
        check("bp latency", lat, 32'd5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = (k != 1);
            mode = 2'b10; a = 5'd1; b = 5'd1;
            @(posedge clk);
            #1;
            check($sformatf("bp%0d sum", k), {27'd0, sum}, 32'd22);
            check($sformatf("bp%0d carry", k), {31'd0, carry}, 32'd0);
            check($sformatf("bp%0d overflow", k), {31'd0, overflow}, 32'd1);
            check($sformatf("bp%0d out_valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp%0d in_ready", k), {31'd0, in_ready}, 32'd0);
            check($sformatf("bp%0d busy", k), {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release in_ready", {31'd0, in_ready}, 32'd1);
        check("bp release out_valid", {31'd0, out_valid}, 32'd0);
        check("bp acc untouched", {27'd0, dut.acc}, 32'd6);
        @(posedge clk);
        #1;
        check("bp pulses ignored busy", {31'd0, busy}, 32'd0);

        // Reset during RUN aborts the operation
        run_op(2'b10, 5'd3, 5'd0, lat);
        @(posedge clk);
        #1;
        check("pre-abort acc", {27'd0, dut.acc}, 32'd9);
        @(negedge clk);
        mode = 2'b00; a = 5'd13; b = 5'd9; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort busy before rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort sum", {27'd0, sum}, 32'd0);
        check("abort carry", {31'd0, carry}, 32'd0);
        check("abort acc", {27'd0, dut.acc}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort no result %0d", k), {31'd0, out_valid}, 32'd0);
        end
        run_op(2'b00, 5'd13, 5'd9, lat);
        check("post-abort latency", lat, 32'd5);
        check("post-abort sum", {27'd0, sum}, 32'd22);
        check("post-abort overflow", {31'd0, overflow}, 32'd1);
        @(posedge clk);
        #1;

        // Single-cycle instance: same results, latency 1
        for (int i = 0; i < 5; i++) begin
            run_op5(vecs[i].mode, vecs[i].a, vecs[i].b, lat);
            check($sformatf("d5 vec%0d latency", i), lat, 32'd1);
            check($sformatf("d5 vec%0d sum", i), {27'd0, sum5}, {27'd0, vecs[i].sum});
            check($sformatf("d5 vec%0d carry", i), {31'd0, carry5}, {31'd0, vecs[i].carry});
            check($sformatf("d5 vec%0d overflow", i), {31'd0, overflow5}, {31'd0, vecs[i].ov});
            @(posedge clk);
            #1;
            check($sformatf("d5 vec%0d in_ready", i), {31'd0, in_ready5}, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
